maxunpool: RTL and testbench
============================

// Module: maxunpool
// PURPOSE
//  2x2/stride-2 max-unpool: inverse of the pooling stage. Scatters each pooled value back
//  to the argmax position (2-bit index) inside its 2x2 window of a full-size map; the other
//  3 positions are 0. Sits in the decoder/upsampling path after pooled activations + indices.
//  Sequential: one window per clock, 2-stage pipeline, done flag handshake.
// PARAMETERS
//  IFMAP_HEIGHT  default IFMAP_HEIGHT (cnn_defs)  rows of full-size output map
//  IFMAP_WIDTH   default IFMAP_WIDTH  (cnn_defs)  cols of full-size output map
//  DATA_WIDTH    default DATA_WIDTH   (cnn_defs)  bits per element
// PORTS
//  clk          in   1                            clock
//  reset        in   1                            asynchronous, active-high reset
//  en           in   1                            start/hold; low returns block to IDLE
//  pooled       in   DATA_WIDTH [PH][PW]          pooled values, PH=IFMAP_HEIGHT/2, PW=IFMAP_WIDTH/2
//  pool_idx     in   2 [PH][PW]                   argmax position per window
//  ofmap        out  DATA_WIDTH [IFMAP_HEIGHT][IFMAP_WIDTH]  reconstructed map
//  done_unpool  out  1                            map complete, held while en=1
// BEHAVIOUR
//  Reset (async): state=IDLE, all ofmap=0, done_unpool=0, counters/pipeline regs=0, valid=0.
//  Idx encoding: 00->(2r,2c) 01->(2r,2c+1) 10->(2r+1,2c) 11->(2r+1,2c+1).
//  States: IDLE -en-> CLEAR -> PROCESS -(count==N)-> DRAIN(2 cyc) -> DONE; N=PH*PW.
//  en low in any state: next state IDLE, done_unpool<=0, ofmap retains contents.
//  CLEAR: one cycle, all ofmap elements <=0; row/col/count <=0.
//  PROCESS: per cycle while count<N: stage1 latches pooled[r][c], pool_idx[r][c], r, c,
//   valid=1; col-major-inner raster (c increments, wraps to 0 at PW-1 with r++); count++.
//  Stage2: if valid, write value to ofmap at decoded (2r+dr, 2c+dc); no other element touched.
//  Latency: window k written at edge k+4 after the edge sampling en=1 in IDLE;
//   done_unpool rises at edge N+6, stays 1 while en=1 (DONE state).
//  Odd IFMAP dims: last row/col never written, remain 0 after CLEAR.
//  en toggled low then high mid-run: restart from CLEAR (full re-clear, no stale data).
//  Inputs must be stable from en rise until done_unpool; sampled per-window, not snapshotted.
//  Widths: count is $clog2(N)+1 bits; r/c $clog2(PH)/$clog2(PW) bits (min 1).
// CONFIGURATION
//  UNPOOL_NEAREST_EN defined: pool_idx ignored; stage2 writes value to all 4 window
//   positions (nearest-neighbour upsample); CLEAR still performed; timing unchanged.
//  Undefined: index-directed scatter as above.
// STRUCTURE
//  cnn_defs.svh: IFMAP_HEIGHT/IFMAP_WIDTH/DATA_WIDTH defaults, unpool_state_t enum
//   {IDLE,CLEAR,PROCESS,DRAIN,DONE}, idx localparams IDX_TL/IDX_TR/IDX_BL/IDX_BR.
//  Sub-module scatter2x2: combinational; (value, idx) -> 4 values + 4 write-enables;
//   under UNPOOL_NEAREST_EN all enables=1.
// TESTING
//  1 4x4, pooled={{9,7},{5,3}}, idx={{00,11},{10,01}}, en=1 -> ofmap[0][0]=9,[1][3]=7,
//    [3][0]=5,[2][3]=3, other 12 =0; done_unpool at edge 10 (N=4).
//  2 Run 1 then en=0 one cycle, rerun with all idx=00, pooled=all 1 -> only [even][even]=1,
//    old positions cleared to 0.
//  3 Reset asserted at edge 6 of a run -> ofmap all 0, done 0 immediately (async);
//    after release + en, correct full result.
//  4 5x5 (PH=PW=2), idx=11 all, pooled=8'hFF -> [1][1],[1][3],[3][1],[3][3]=FF;
//    row 4 and col 4 all 0.
//  5 UNPOOL_NEAREST_EN, 4x4 pooled={{1,2},{3,4}} -> each 2x2 block filled with its value.
//  6 en held after done -> done_unpool stays 1, ofmap stable 20 cycles; en=0 -> done 0 next edge.

Source files
------------

// File: rtl/maxunpool_pkg.sv
// Shared definitions for the max-unpool block: default map geometry, FSM states, argmax index codes.
package maxunpool_pkg;

   localparam int CNN_IFMAP_HEIGHT = 4;
   localparam int CNN_IFMAP_WIDTH  = 4;
   localparam int CNN_DATA_WIDTH   = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      PROCESS,
      DRAIN,
      DONE
   } unpool_state_t;

   // Window position = {row offset, col offset}
   localparam logic [1:0] IDX_TL = 2'b00;
   localparam logic [1:0] IDX_TR = 2'b01;
   localparam logic [1:0] IDX_BL = 2'b10;
   localparam logic [1:0] IDX_BR = 2'b11;

   function automatic int clog2_min1(input int v);
      return ($clog2(v) < 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/maxunpool_scatter2x2.sv
// Combinational 2x2 scatter: one value plus argmax index -> four window values and write-enables.
// UNPOOL_NEAREST_EN: index ignored, value replicated to all four positions.
module scatter2x2
   import maxunpool_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]      i_value,
   input  logic [1:0]                 i_idx,
   output logic [3:0][DATA_WIDTH-1:0] o_vals,
   output logic [3:0]                 o_we
);

   always_comb begin
      o_vals = '0;
      o_we   = '0;
`ifdef UNPOOL_NEAREST_EN
      o_we   = 4'b1111;
      for (int p = 0; p < 4; p++) begin
         o_vals[p] = i_value;
      end
`else
      case (i_idx)
         IDX_TL: begin o_we[0] = 1'b1; o_vals[0] = i_value; end
         IDX_TR: begin o_we[1] = 1'b1; o_vals[1] = i_value; end
         IDX_BL: begin o_we[2] = 1'b1; o_vals[2] = i_value; end
         default: begin o_we[3] = 1'b1; o_vals[3] = i_value; end
      endcase
`endif
   end

endmodule

// File: rtl/maxunpool.sv
// 2x2/stride-2 max-unpool: clears the map, then scatters one pooled window per clock through a
// 2-stage pipeline and raises done_unpool. Build option UNPOOL_NEAREST_EN selects nearest upsample.
module maxunpool
   import maxunpool_pkg::*;
#(
   parameter int IFMAP_HEIGHT = CNN_IFMAP_HEIGHT,
   parameter int IFMAP_WIDTH  = CNN_IFMAP_WIDTH,
   parameter int DATA_WIDTH   = CNN_DATA_WIDTH
) (
   input  logic                                                     clk,
   input  logic                                                     reset,
   input  logic                                                     en,
   input  logic [IFMAP_HEIGHT/2-1:0][IFMAP_WIDTH/2-1:0][DATA_WIDTH-1:0] pooled,
   input  logic [IFMAP_HEIGHT/2-1:0][IFMAP_WIDTH/2-1:0][1:0]            pool_idx,
   output logic [IFMAP_HEIGHT-1:0][IFMAP_WIDTH-1:0][DATA_WIDTH-1:0]     ofmap,
   output logic                                                     done_unpool
);

   localparam int PH  = IFMAP_HEIGHT / 2;
   localparam int PW  = IFMAP_WIDTH / 2;
   localparam int N   = PH * PW;
   localparam int CW  = $clog2(N) + 1;
   localparam int RW  = clog2_min1(PH);
   localparam int CLW = clog2_min1(PW);

   unpool_state_t r_state, w_next;

   logic [RW-1:0]             r_row, r_s1_row;
   logic [CLW-1:0]            r_col, r_s1_col;
   logic [CW-1:0]             r_count;
   logic                      r_drain;
   logic                      r_s1_vld;
   logic [DATA_WIDTH-1:0]     r_s1_val;
   logic [1:0]                r_s1_idx;
   logic                      w_clear;
   logic                      w_issue;
   logic [3:0][DATA_WIDTH-1:0] w_vals;
   logic [3:0]                w_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      w_issue = 1'b0;
      if (!en) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_next = CLEAR;
            CLEAR: begin
               w_next  = PROCESS;
               w_clear = 1'b1;
            end
            PROCESS: begin
               if (r_count == CW'(N)) w_next = DRAIN;
               else                   w_issue = 1'b1;
            end
            DRAIN:   if (r_drain) w_next = DONE;
            DONE:    w_next = DONE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Stage 1: raster walk over windows, column index fastest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row       <= '0;
         r_col       <= '0;
         r_count     <= '0;
         r_drain     <= 1'b0;
         r_s1_vld    <= 1'b0;
         r_s1_val    <= '0;
         r_s1_idx    <= '0;
         r_s1_row    <= '0;
         r_s1_col    <= '0;
         done_unpool <= 1'b0;
      end else begin
         if (w_clear) begin
            r_row   <= '0;
            r_col   <= '0;
            r_count <= '0;
         end else if (w_issue) begin
            r_s1_val <= pooled[r_row][r_col];
            r_s1_idx <= pool_idx[r_row][r_col];
            r_s1_row <= r_row;
            r_s1_col <= r_col;
            if (r_col == CLW'(PW - 1)) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
            r_count <= r_count + 1'b1;
         end
         r_s1_vld    <= w_issue;
         r_drain     <= (en && r_state == DRAIN) ? ~r_drain : 1'b0;
         done_unpool <= en && (r_state == DONE);
      end
   end

   scatter2x2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_scatter (
      .i_value(r_s1_val),
      .i_idx  (r_s1_idx),
      .o_vals (w_vals),
      .o_we   (w_we)
   );

   // Stage 2: only the enabled positions of the latched window are written;
   // an odd trailing row/column lies outside every window and keeps its cleared value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ofmap <= '0;
      end else if (w_clear) begin
         ofmap <= '0;
      end else if (en && r_s1_vld) begin
         for (int i = 0; i < 2 * PH; i++) begin
            for (int j = 0; j < 2 * PW; j++) begin
               if ((i / 2 == int'(r_s1_row)) && (j / 2 == int'(r_s1_col)) &&
                   w_we[(i % 2) * 2 + (j % 2)]) begin
                  ofmap[i][j] <= w_vals[(i % 2) * 2 + (j % 2)];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_maxunpool.sv
// Directed bench for maxunpool: 4x4 and 5x5 instances, edge-accurate latency and done checks.
// Build with UNPOOL_NEAREST_EN defined to exercise the nearest-neighbour variant.
module tb_maxunpool;

   logic clk = 1'b0;
   logic reset;
   logic en4, en5;
   logic [1:0][1:0][7:0] pooled4, pooled5;
   logic [1:0][1:0][1:0] idx4, idx5;
   logic [3:0][3:0][7:0] ofmap4;
   logic [4:0][4:0][7:0] ofmap5;
   logic done4, done5;

   logic [3:0][3:0][7:0] e4;
   logic [4:0][4:0][7:0] e5;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   maxunpool #(.IFMAP_HEIGHT(4), .IFMAP_WIDTH(4), .DATA_WIDTH(8)) u4 (
      .clk(clk), .reset(reset), .en(en4), .pooled(pooled4), .pool_idx(idx4),
      .ofmap(ofmap4), .done_unpool(done4)
   );

   maxunpool #(.IFMAP_HEIGHT(5), .IFMAP_WIDTH(5), .DATA_WIDTH(8)) u5 (
      .clk(clk), .reset(reset), .en(en5), .pooled(pooled5), .pool_idx(idx5),
      .ofmap(ofmap5), .done_unpool(done5)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_run1();
      pooled4[0][0] = 8'd9; pooled4[0][1] = 8'd7;
      pooled4[1][0] = 8'd5; pooled4[1][1] = 8'd3;
      idx4[0][0] = 2'b00; idx4[0][1] = 2'b11;
      idx4[1][0] = 2'b10; idx4[1][1] = 2'b01;
   endtask

   initial begin
      reset = 1'b1;
      en4 = 1'b0;
      en5 = 1'b0;
      pooled4 = '0;
      idx4 = '0;
      pooled5 = {4{8'hFF}};
      idx5 = {4{2'b11}};
      tick(2);
      check("rst_map4", {128'b0, ofmap4}, 256'b0);
      check("rst_done4", {255'b0, done4}, 256'b0);
      check("rst_map5", {56'b0, ofmap5}, 256'b0);
      check("rst_done5", {255'b0, done5}, 256'b0);
      reset = 1'b0;
      tick(1);

`ifndef UNPOOL_NEAREST_EN
      // Run 1: scatter with mixed indices, edge-accurate latency
      load_run1();
      en4 = 1'b1;
      tick(3);
      check("t1_w0_not_yet_e3", {248'b0, ofmap4[0][0]}, 256'b0);
      tick(1);
      check("t1_w0_at_e4", {248'b0, ofmap4[0][0]}, 256'd9);
      check("t1_w1_not_yet_e4", {248'b0, ofmap4[1][3]}, 256'b0);
      tick(5);
      check("t1_done_low_e9", {255'b0, done4}, 256'b0);
      tick(1);
      check("t1_done_e10", {255'b0, done4}, 256'd1);
      e4 = '0;
      e4[0][0] = 8'd9; e4[1][3] = 8'd7; e4[3][0] = 8'd5; e4[2][3] = 8'd3;
      check("t1_map", {128'b0, ofmap4}, {128'b0, e4});

      // Held en after done: output and flag must stay put
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (i % 5 == 4) begin
            check("t6_done_hold", {255'b0, done4}, 256'd1);
            check("t6_map_hold", {128'b0, ofmap4}, {128'b0, e4});
         end
      end
      en4 = 1'b0;
      tick(1);
      check("t6_done_drop", {255'b0, done4}, 256'b0);
      check("t6_map_retained", {128'b0, ofmap4}, {128'b0, e4});

      // Run 2: rerun with new data must clear the old positions
      pooled4 = {4{8'd1}};
      idx4 = '0;
      en4 = 1'b1;
      tick(2);
      check("t2_cleared_e2", {128'b0, ofmap4}, 256'b0);
      tick(7);
      check("t2_done_low_e9", {255'b0, done4}, 256'b0);
      tick(1);
      check("t2_done_e10", {255'b0, done4}, 256'd1);
      e4 = '0;
      e4[0][0] = 8'd1; e4[0][2] = 8'd1; e4[2][0] = 8'd1; e4[2][2] = 8'd1;
      check("t2_map", {128'b0, ofmap4}, {128'b0, e4});

      // Run 3: asynchronous reset mid-run, then a clean full run
      en4 = 1'b0;
      tick(1);
      load_run1();
      en4 = 1'b1;
      tick(5);
      e4 = '0;
      e4[0][0] = 8'd9; e4[1][3] = 8'd7;
      check("t3_partial_e5", {128'b0, ofmap4}, {128'b0, e4});
      tick(1);
      reset = 1'b1;
      en4 = 1'b0;
      #1;
      check("t3_async_map", {128'b0, ofmap4}, 256'b0);
      check("t3_async_done", {255'b0, done4}, 256'b0);
      tick(1);
      reset = 1'b0;
      en4 = 1'b1;
      tick(10);
      check("t3_done_e10", {255'b0, done4}, 256'd1);
      e4 = '0;
      e4[0][0] = 8'd9; e4[1][3] = 8'd7; e4[3][0] = 8'd5; e4[2][3] = 8'd3;
      check("t3_map", {128'b0, ofmap4}, {128'b0, e4});
      en4 = 1'b0;
      tick(1);
`else
      // Nearest-neighbour: each 2x2 block carries its pooled value
      pooled4[0][0] = 8'd1; pooled4[0][1] = 8'd2;
      pooled4[1][0] = 8'd3; pooled4[1][1] = 8'd4;
      idx4 = '0;
      en4 = 1'b1;
      tick(4);
      check("t5_w0_e4", {248'b0, ofmap4[1][1]}, 256'd1);
      tick(5);
      check("t5_done_low_e9", {255'b0, done4}, 256'b0);
      tick(1);
      check("t5_done_e10", {255'b0, done4}, 256'd1);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            e4[r][c] = 8'((r / 2) * 2 + (c / 2) + 1);
      check("t5_map", {128'b0, ofmap4}, {128'b0, e4});
      en4 = 1'b0;
      tick(1);
      check("t5_done_drop", {255'b0, done4}, 256'b0);
`endif

      // Odd 5x5 map: trailing row and column never written
      check("t4_map_idle", {56'b0, ofmap5}, 256'b0);
      en5 = 1'b1;
      tick(9);
      check("t4_done_low_e9", {255'b0, done5}, 256'b0);
      tick(1);
      check("t4_done_e10", {255'b0, done5}, 256'd1);
      e5 = '0;
`ifndef UNPOOL_NEAREST_EN
      e5[1][1] = 8'hFF; e5[1][3] = 8'hFF; e5[3][1] = 8'hFF; e5[3][3] = 8'hFF;
`else
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            e5[r][c] = 8'hFF;
`endif
      check("t4_map", {56'b0, ofmap5}, {56'b0, e5});
      check("t4_row4", {216'b0, ofmap5[4]}, 256'b0);
      en5 = 1'b0;
      tick(1);
      check("t4_done_drop", {255'b0, done5}, 256'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
